// File: rtl/btb_param.sv
// Direct-mapped branch target buffer with 2-bit direction counters and a
// circular return-address stack; lookup is combinational, updates land on the clock edge.
module btb_param #(
    parameter int ENTRIES   = 16,
    parameter int ADDR_W    = 32,
    parameter int RAS_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] pc,
    output logic              predict_valid,
    output logic              predict_taken,
    output logic [ADDR_W-1:0] predict_target,
    output logic              predict_is_ret,
    input  logic              update_en,
    input  logic [ADDR_W-1:0] update_pc,
    input  logic              actual_taken,
    input  logic [ADDR_W-1:0] update_target,
    input  logic [1:0]        update_type,
    output logic              ras_empty
);
    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = ADDR_W - IDX_W - 2;
    localparam int PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int CNT_W = $clog2(RAS_DEPTH + 1);

    localparam logic [1:0] T_BRANCH = 2'b00;
    localparam logic [1:0] T_CALL   = 2'b10;
    localparam logic [1:0] T_RET    = 2'b11;

    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(RAS_DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(RAS_DEPTH);

    logic              valid_q  [ENTRIES];
    logic [TAG_W-1:0]  tag_q    [ENTRIES];
    logic [ADDR_W-1:0] target_q [ENTRIES];
    logic [1:0]        ctr_q    [ENTRIES];
    logic [1:0]        type_q   [ENTRIES];

    logic [ADDR_W-1:0] ras_q [RAS_DEPTH];
    logic [PTR_W-1:0]  ptr_q, ptr_d, top_idx;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    // Low PC bits are always zero for aligned instructions.
    logic unused_bits;
    assign unused_bits = ^{pc[1:0], update_pc[1:0]};

    // ---------------- lookup ----------------
    logic [IDX_W-1:0] lk_idx;
    logic [TAG_W-1:0] lk_tag;
    logic [ADDR_W-1:0] ras_top;

    assign lk_idx    = pc[IDX_W+1:2];
    assign lk_tag    = pc[ADDR_W-1:IDX_W+2];
    assign top_idx   = (ptr_q == '0) ? PTR_LAST : ptr_q - PTR_W'(1);
    assign ras_top   = ras_q[top_idx];
    assign ras_empty = (cnt_q == '0);

    always_comb begin
        predict_valid  = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
        predict_taken  = predict_valid && ((type_q[lk_idx] != T_BRANCH) || ctr_q[lk_idx][1]);
        predict_is_ret = predict_valid && (type_q[lk_idx] == T_RET);
        if (predict_is_ret && !ras_empty)
            predict_target = ras_top;
        else if (predict_taken)
            predict_target = target_q[lk_idx];
        else
            predict_target = pc + ADDR_W'(4);
    end

    // ---------------- table update ----------------
    logic [IDX_W-1:0] u_idx;
    logic [TAG_W-1:0] u_tag;
    logic             u_hit, u_alloc, u_write;
    logic [1:0]       ctr_cur, ctr_hit_d;

    always_comb begin
        u_idx     = update_pc[IDX_W+1:2];
        u_tag     = update_pc[ADDR_W-1:IDX_W+2];
        u_hit     = valid_q[u_idx] && (tag_q[u_idx] == u_tag);
        u_alloc   = !u_hit && (actual_taken || (update_type != T_BRANCH));
        u_write   = rst && update_en && (u_hit || u_alloc);
        ctr_cur   = ctr_q[u_idx];
        if (actual_taken)
            ctr_hit_d = (ctr_cur == 2'b11) ? ctr_cur : ctr_cur + 2'b01;
        else
            ctr_hit_d = (ctr_cur == 2'b00) ? ctr_cur : ctr_cur - 2'b01;
    end

    for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_entry
        logic sel;
        assign sel = u_write && (u_idx == IDX_W'(gi));

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                valid_q[gi] <= 1'b0;
                ctr_q[gi]   <= 2'b01;
            end else if (sel) begin
                valid_q[gi] <= 1'b1;
                ctr_q[gi]   <= u_hit ? ctr_hit_d : 2'b10;
            end
        end

        // Payload needs no reset: it is only observed through a set valid bit.
        always_ff @(posedge clk) begin
            if (sel) begin
                tag_q[gi]  <= u_tag;
                type_q[gi] <= update_type;
                if (u_alloc || actual_taken)
                    target_q[gi] <= update_target;
            end
        end
    end

    // ---------------- return-address stack ----------------
    logic push, pop;
    assign push = rst && update_en && (update_type == T_CALL);
    assign pop  = rst && update_en && (update_type == T_RET) && !ras_empty;

    always_comb begin
        ptr_d = ptr_q;
        cnt_d = cnt_q;
        if (push) begin
            ptr_d = (ptr_q == PTR_LAST) ? '0 : ptr_q + PTR_W'(1);
            cnt_d = (cnt_q == CNT_FULL) ? cnt_q : cnt_q + CNT_W'(1);
        end else if (pop) begin
            ptr_d = top_idx;
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q <= '0;
            cnt_q <= '0;
        end else begin
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
        end
    end

    // Writing at the pointer when full naturally overwrites the oldest slot.
    for (genvar gi = 0; gi < RAS_DEPTH; gi++) begin : g_ras
        always_ff @(posedge clk) begin
            if (push && (ptr_q == PTR_W'(gi)))
                ras_q[gi] <= update_pc + ADDR_W'(4);
        end
    end
endmodule

// File: tb/tb_btb_param.sv
// Directed bench for btb_param: counter training, aliasing, RAS behaviour and async reset.
module tb_btb_param;
    localparam logic [1:0] BR = 2'b00, CALL = 2'b10, RET = 2'b11;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc;
    logic        predict_valid, predict_taken, predict_is_ret, ras_empty;
    logic [31:0] predict_target;
    logic        update_en;
    logic [31:0] update_pc;
    logic        actual_taken;
    logic [31:0] update_target;
    logic [1:0]  update_type;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    btb_param #(.ENTRIES(16), .ADDR_W(32), .RAS_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .pc(pc),
        .predict_valid(predict_valid), .predict_taken(predict_taken),
        .predict_target(predict_target), .predict_is_ret(predict_is_ret),
        .update_en(update_en), .update_pc(update_pc), .actual_taken(actual_taken),
        .update_target(update_target), .update_type(update_type),
        .ras_empty(ras_empty)
    );

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", name, obs, exp);
        end
    endtask

    task automatic look(input string name, input logic [31:0] p, input logic v,
                        input logic tk, input logic [31:0] tgt, input logic r);
        pc = p;
        #1;
        check({name, "_valid"},  32'(predict_valid),  32'(v));
        check({name, "_taken"},  32'(predict_taken),  32'(tk));
        check({name, "_target"}, predict_target,      tgt);
        check({name, "_is_ret"}, 32'(predict_is_ret), 32'(r));
        $display("look %-12s pc=%h valid=%0b taken=%0b target=%h is_ret=%0b",
                 name, p, predict_valid, predict_taken, predict_target, predict_is_ret);
    endtask

    task automatic upd(input logic [31:0] p, input logic t, input logic [31:0] tg, input logic [1:0] ty);
        update_pc     = p;
        actual_taken  = t;
        update_target = tg;
        update_type   = ty;
        update_en     = 1'b1;
        @(posedge clk);
        #1;
        update_en = 1'b0;
        $display("upd  pc=%h taken=%0b target=%h type=%0d ras_empty=%0b", p, t, tg, ty, ras_empty);
    endtask

    initial begin
        rst = 1'b0;
        update_en = 1'b0; update_pc = '0; actual_taken = 1'b0;
        update_target = '0; update_type = BR;
        pc = 32'h100;
        #1;
        look("in_reset", 32'h100, 0, 0, 32'h104, 0);
        check("in_reset_ras_empty", 32'(ras_empty), 32'd1);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;

        look("post_reset", 32'h100, 0, 0, 32'h104, 0);
        check("post_reset_ras_empty", 32'(ras_empty), 32'd1);

        // Counter training on a single branch
        upd(32'h100, 1, 32'h200, BR);
        look("alloc", 32'h100, 1, 1, 32'h200, 0);
        upd(32'h100, 0, 32'h999, BR);
        upd(32'h100, 0, 32'h999, BR);
        look("ctr00", 32'h100, 1, 0, 32'h104, 0);
        upd(32'h100, 1, 32'h200, BR);
        look("ctr01", 32'h100, 1, 0, 32'h104, 0);
        upd(32'h100, 1, 32'h200, BR);
        look("ctr10", 32'h100, 1, 1, 32'h200, 0);

        // Same-cycle lookup sees pre-update contents
        pc = 32'h100;
        update_pc = 32'h100; actual_taken = 1'b0; update_target = 32'h999;
        update_type = BR; update_en = 1'b1;
        #1;
        check("same_cycle_pre", 32'(predict_taken), 32'd1);
        @(posedge clk);
        #1 update_en = 1'b0;
        check("same_cycle_post", 32'(predict_taken), 32'd0);

        // Aliasing at index 0
        look("alias_miss", 32'h140, 0, 0, 32'h144, 0);
        upd(32'h140, 1, 32'h500, BR);
        look("alias_hit", 32'h140, 1, 1, 32'h500, 0);
        look("alias_evict", 32'h100, 0, 0, 32'h104, 0);
        upd(32'h100, 0, 32'h777, BR);
        look("nt_miss_keep", 32'h140, 1, 1, 32'h500, 0);

        // Saturation at 11: two more taken, then one not-taken stays taken
        upd(32'h140, 1, 32'h500, BR);
        upd(32'h140, 1, 32'h500, BR);
        upd(32'h140, 0, 32'h500, BR);
        look("sat11", 32'h140, 1, 1, 32'h500, 0);

        // Call/return pairing
        upd(32'h300, 1, 32'h400, CALL);
        check("call_ras_nonempty", 32'(ras_empty), 32'd0);
        upd(32'h480, 1, 32'h304, RET);
        check("ret_ras_empty", 32'(ras_empty), 32'd1);
        look("ret_stored", 32'h480, 1, 1, 32'h304, 1);
        upd(32'h2014, 1, 32'h9000, RET);
        check("pop_empty_noop", 32'(ras_empty), 32'd1);
        look("ret2_stored", 32'h2014, 1, 1, 32'h9000, 1);
        upd(32'h600, 1, 32'h700, CALL);
        check("call600_ras", 32'(ras_empty), 32'd0);
        look("ret480_aliased", 32'h480, 0, 0, 32'h484, 0);
        look("ret_from_ras", 32'h2014, 1, 1, 32'h604, 1);
        look("call600_hit", 32'h600, 1, 1, 32'h700, 0);

        // RAS overflow wraps; pops return the newest four
        for (int i = 0; i < 5; i++) upd(32'h1000 + 32'(16 * i), 1, 32'h5000, CALL);
        check("five_calls_ras", 32'(ras_empty), 32'd0);
        for (int k = 0; k < 4; k++) begin
            look($sformatf("pop%0d", k), 32'h2014, 1, 1, 32'h1044 - 32'(16 * k), 1);
            upd(32'h2014, 1, 32'h1044 - 32'(16 * k), RET);
        end
        check("drained_ras_empty", 32'(ras_empty), 32'd1);
        look("drained", 32'h2014, 1, 1, 32'h1014, 1);
        upd(32'h2014, 1, 32'h7770, RET);
        check("fifth_pop_empty", 32'(ras_empty), 32'd1);
        look("fifth_pop", 32'h2014, 1, 1, 32'h7770, 1);
        upd(32'h3000, 1, 32'h5000, CALL);
        look("push_after_noop", 32'h2014, 1, 1, 32'h3004, 1);

        // Asynchronous reset mid-stream, strobes ignored while held
        rst = 1'b0;
        look("async_rst", 32'h2014, 0, 0, 32'h2018, 0);
        check("async_rst_ras", 32'(ras_empty), 32'd1);
        update_pc = 32'h100; actual_taken = 1'b1; update_target = 32'h200;
        update_type = CALL; update_en = 1'b1;
        repeat (2) @(posedge clk);
        #1 update_en = 1'b0;
        rst = 1'b1;
        look("rel_2014", 32'h2014, 0, 0, 32'h2018, 0);
        look("rel_100", 32'h100, 0, 0, 32'h104, 0);
        look("rel_140", 32'h140, 0, 0, 32'h144, 0);
        check("rel_ras_empty", 32'(ras_empty), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
